traffic_light_fsm: RTL and testbench

Sensor-actuated traffic-light controller for a main/side street intersection with a pedestrian walk phase. It is the initiator side of the timer handshake: each phase loads a duration into the countdown timer with `value`/`start_timer` and advances when the timer reports `expired`. It sits directly above the timer in the intersection top level. Timer outputs feed its inputs; its `value`/`start_timer` feed the timer.

---
 rtl/traffic_light_fsm.sv | 115 +++++++++++
 tb/tb_traffic_light_fsm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_fsm.sv
// Sensor-actuated main/side street traffic-light controller with a pedestrian walk phase.
// Each state entry loads its duration into an external countdown timer and advances on an armed expiry.
module traffic_light_fsm #(
    parameter logic [4:0] T_BASE = 5'd6,
    parameter logic [4:0] T_EXT  = 5'd3,
    parameter logic [4:0] T_YEL  = 5'd2,
    parameter logic [4:0] T_WALK = 5'd4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       expired,
    input  logic       sensor,
    input  logic       walk_request,
    output logic [4:0] value,
    output logic       start_timer,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_light,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        MG     = 3'd0,
        MG_EXT = 3'd1,
        MY     = 3'd2,
        SG     = 3'd3,
        SG_EXT = 3'd4,
        SY     = 3'd5,
        WALK   = 3'd6,
        ST_BAD = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic   armed_q;
    logic   init_q;
    logic   walk_pending_q;
    logic   walk_pend_any;
    logic   load_d;

    function automatic logic [4:0] duration(input state_t s);
        logic [4:0] d;
        case (s)
            MG, SG:         d = T_BASE;
            MG_EXT, SG_EXT: d = T_EXT;
            MY, SY:         d = T_YEL;
            WALK:           d = T_WALK;
            default:        d = T_BASE;
        endcase
        return d;
    endfunction

    // Packed as {main RYG, side RYG, walk}.
    function automatic logic [6:0] lamps(input state_t s);
        logic [6:0] l;
        case (s)
            MG, MG_EXT: l = 7'b001_100_0;
            MY:         l = 7'b010_100_0;
            SG, SG_EXT: l = 7'b100_001_0;
            SY:         l = 7'b100_010_0;
            WALK:       l = 7'b100_100_1;
            default:    l = 7'b001_100_0;
        endcase
        return l;
    endfunction

    // A request arriving in the decision cycle itself still counts.
    always_comb begin
        walk_pend_any = walk_pending_q | walk_request;
        state_d       = state_q;
        load_d        = init_q;
        if (state_q == ST_BAD) begin
            state_d = MG;
            load_d  = 1'b1;
        end else if (armed_q && expired) begin
            load_d = 1'b1;
            case (state_q)
                MG, MG_EXT: state_d = (sensor || walk_pend_any) ? MY : MG_EXT;
                MY:         state_d = SG;
                SG:         state_d = sensor ? SG_EXT : SY;
                SG_EXT:     state_d = SY;
                SY:         state_d = walk_pend_any ? WALK : MG;
                default:    state_d = MG;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= MG;
            walk_pending_q <= 1'b0;
            armed_q        <= 1'b0;
            init_q         <= 1'b1;
            start_timer    <= 1'b0;
            value          <= 5'd0;
            {main_light, side_light, walk_light} <= lamps(MG);
        end else begin
            init_q <= 1'b0;
            // The WALK entry cycle consumes the request; a new one in that same cycle survives.
            walk_pending_q <= (state_q == WALK && start_timer) ? walk_request : walk_pend_any;
            if (load_d) begin
                state_q     <= state_d;
                start_timer <= 1'b1;
                value       <= duration(state_d);
                armed_q     <= 1'b0;
                {main_light, side_light, walk_light} <= lamps(state_d);
            end else begin
                start_timer <= 1'b0;
                armed_q     <= 1'b1;
            end
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm: a phase-level reference model predicts every timer load,
// a monitor on the falling edge pops and compares them and checks lamps/value every cycle.
module tb_traffic_light_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       expired;
    logic [4:0] value;
    logic       start_timer;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_light;
    logic [2:0] state_out;

    always #5 clock = ~clock;

    traffic_light_fsm #(
        .T_BASE(5'd6),
        .T_EXT (5'd3),
        .T_YEL (5'd2),
        .T_WALK(5'd4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .expired     (expired),
        .sensor      (sensor),
        .walk_request(walk_request),
        .value       (value),
        .start_timer (start_timer),
        .main_light  (main_light),
        .side_light  (side_light),
        .walk_light  (walk_light),
        .state_out   (state_out)
    );

    // Behavioural countdown timer
    logic [4:0] tcnt = 5'd0;
    always @(posedge clock) begin
        if (start_timer) tcnt <= value;
        else if (tcnt != 5'd0) tcnt <= tcnt - 5'd1;
    end
    assign expired = (tcnt == 5'd0);

    // Phase tables indexed by state number: MG, MG_EXT, MY, SG, SG_EXT, SY, WALK
    int DUR  [7] = '{6, 3, 2, 6, 3, 2, 4};
    int MAINL[7] = '{1, 1, 2, 4, 4, 4, 4};
    int SIDEL[7] = '{4, 4, 4, 1, 1, 2, 4};

    typedef struct {
        int ph;
        int val;
    } load_t;
    load_t exp_q[$];

    int n_vec = 0;
    int n_fail = 0;
    int dut_walks = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a phase lasts its duration plus two cycles (load cycle + timer reaching 0)
    int m_ph = 0, m_age = 0, m_val = 0;
    bit m_init = 1'b1, m_pend = 1'b0, m_start = 1'b0;
    bit pe;
    int nxt;

    function automatic void do_load(input int p);
        load_t e;
        m_ph = p;
        m_age = 0;
        m_val = DUR[p];
        m_start = 1'b1;
        e.ph = p;
        e.val = DUR[p];
        exp_q.push_back(e);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_ph = 0; m_age = 0; m_val = 0; m_init = 1'b1; m_pend = 1'b0; m_start = 1'b0;
        end else if (m_init) begin
            m_init = 1'b0;
            m_pend = m_pend | walk_request;
            do_load(0);
        end else begin
            pe = m_pend | walk_request;
            if (m_ph == 6 && m_age == 0) m_pend = walk_request;
            else m_pend = pe;
            if (m_age == DUR[m_ph] + 1) begin
                case (m_ph)
                    0, 1:    nxt = (sensor || pe) ? 2 : 1;
                    2:       nxt = 3;
                    3:       nxt = sensor ? 4 : 5;
                    4:       nxt = 5;
                    5:       nxt = pe ? 6 : 0;
                    default: nxt = 0;
                endcase
                do_load(nxt);
            end else begin
                m_age++;
                m_start = 1'b0;
            end
        end
    end

    // Monitor
    load_t e_pop;
    always @(negedge clock) begin
        if (mon_en) begin
            if (start_timer) begin
                if (state_out == 3'd6) dut_walks++;
                if (exp_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_load: got state %0d value %0d, expected no load", state_out, value);
                end else begin
                    e_pop = exp_q.pop_front();
                    chk("load_value", int'(value), e_pop.val);
                    chk("load_state", int'(state_out), e_pop.ph);
                end
            end else if (exp_q.size() != 0) begin
                e_pop = exp_q.pop_front();
                n_vec++; n_fail++;
                $display("FAIL missing_load: got no load, expected state %0d value %0d", e_pop.ph, e_pop.val);
            end
            chk("start_timer", int'(start_timer), int'(m_start));
            chk("value", int'(value), m_val);
            chk("state_out", int'(state_out), m_ph);
            chk("main_light", int'(main_light), MAINL[m_ph]);
            chk("side_light", int'(side_light), SIDEL[m_ph]);
            chk("walk_light", int'(walk_light), (m_ph == 6) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    bit found;
    int w0;

    initial begin
        reset = 1'b1;
        step();
        step();
        mon_en = 1'b1;
        step();
        reset = 1'b0;

        // Idle: MG then endless MG_EXT
        repeat (40) step();

        // Sensor held: full main/side cycle with one side extension
        sensor = 1'b1;
        repeat (50) step();
        sensor = 1'b0;

        // Single walk pulse in MG cycle 3
        reset = 1'b1; step(); reset = 1'b0;
        repeat (3) step();
        walk_request = 1'b1; step(); walk_request = 1'b0;
        repeat (60) step();

        // Reset in cycle 3 of SG_EXT
        sensor = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_ph == 4 && m_age == 3) found = 1'b1;
            else step();
        end
        chk("reach_sg_ext_cycle3", int'(found), 1);
        reset = 1'b1;
        step();
        chk("mid_reset_start", int'(start_timer), 0);
        chk("mid_reset_value", int'(value), 0);
        chk("mid_reset_state", int'(state_out), 0);
        reset = 1'b0;
        sensor = 1'b0;
        step();
        chk("post_reset_start", int'(start_timer), 1);
        chk("post_reset_value", int'(value), 6);

        // Walk request landing exactly in the WALK entry cycle
        walk_request = 1'b1; step(); walk_request = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_ph == 6 && m_age == 0) found = 1'b1;
            else step();
        end
        chk("reach_walk_entry", int'(found), 1);
        walk_request = 1'b1; step(); walk_request = 1'b0;
        w0 = dut_walks;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (dut_walks > w0) found = 1'b1;
            else step();
        end
        chk("second_walk_served", int'(found), 1);

        // Randomized traffic, walk pulses and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) sensor = ~sensor;
            walk_request = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        walk_request = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
